// File: rtl/usb_out_pkg.sv
// Shared definitions for the USB OUT-endpoint sink: FSM encodings and size constants.
package usb_out_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam int DEFAULT_DEPTH_LOG2 = 7;
  localparam int MAX_PKT_SIZE       = 64;

endpackage

// File: rtl/usb_out_fifo_mem.sv
// Byte RAM for the OUT-endpoint FIFO: synchronous write, asynchronous read.
module usb_out_fifo_mem #(
  parameter int AW = 7
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [2**AW];

  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_ep_out_sink.sv
// USB 1.1 OUT-endpoint sink: buffers core writes in a FIFO and streams them out as valid/ready bytes.
// Define USB_OUT_CRC_ROLLBACK_EN to hold packet bytes until a CRC-clean packet end (bad packets are rolled back).
module usb_ep_out_sink
  import usb_out_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int OUT_EP_NUM = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  usb_rst,
  input  logic                  usb_busy,
  input  logic [3:0]            ep_sel,
  input  logic                  crc16_err,
  input  logic [7:0]            ep_dout,
  input  logic                  ep_we,
  output logic                  ep_full,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           pkt_cnt,
  output logic                  overflow
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [PW-1:0] w_fill, w_level, w_wr_nxt;
  logic          r_err_seen, r_busy_q, r_overflow;
  logic [15:0]   r_pkt_cnt;
  logic          w_push, w_pop, w_busy_fall;
  logic          w_enter_recv, w_pkt_end, w_pkt_good;

  assign w_fill      = r_wr_ptr - r_rd_ptr;
  assign w_level     = r_commit_ptr - r_rd_ptr;
  assign ep_full     = (w_fill == DEPTH);
  assign m_valid     = (w_level != '0);
  assign level       = w_level;
  assign pkt_cnt     = r_pkt_cnt;
  assign overflow    = r_overflow;
  assign w_push      = ep_we & ~ep_full;
  assign w_pop       = m_valid & m_ready;
  assign w_busy_fall = r_busy_q & ~usb_busy;
  assign w_wr_nxt    = r_wr_ptr + {{DEPTH_LOG2{1'b0}}, w_push};

  usb_out_fifo_mem #(.AW(DEPTH_LOG2)) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (ep_dout),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (m_data)
  );

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)       r_state <= ST_IDLE;
    else if (usb_rst) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (ep_we && usb_busy && (ep_sel == 4'(OUT_EP_NUM))) w_state_nxt = ST_RECV;
      ST_RECV: if (w_busy_fall) w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_enter_recv = (r_state == ST_IDLE) && (w_state_nxt == ST_RECV);
    w_pkt_end    = (r_state == ST_RECV) && (w_state_nxt == ST_IDLE);
    w_pkt_good   = w_pkt_end && !r_err_seen;
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_busy_q   <= 1'b0;
      r_err_seen <= 1'b0;
    end else begin
      r_busy_q <= usb_busy;
      if (usb_rst || w_enter_recv)               r_err_seen <= 1'b0;
      else if (r_state == ST_RECV && crc16_err)  r_err_seen <= 1'b1;
    end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_cnt    <= '0;
      r_overflow   <= 1'b0;
    end else if (usb_rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_cnt    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_pop)           r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (ep_we && ep_full) r_overflow <= 1'b1;
      if (w_pkt_good)      r_pkt_cnt  <= r_pkt_cnt + 16'd1;
`ifdef USB_OUT_CRC_ROLLBACK_EN
      // a byte landing on the closing cycle belongs to the committed packet
      if (w_pkt_end && r_err_seen) r_wr_ptr <= r_commit_ptr;
      else                         r_wr_ptr <= w_wr_nxt;
      if (w_pkt_good)              r_commit_ptr <= w_wr_nxt;
`else
      r_wr_ptr     <= w_wr_nxt;
      r_commit_ptr <= w_wr_nxt;
`endif
    end

endmodule

// File: doc/usb_ep_out_sink.md
# usb_ep_out_sink

Receive-side sink for one USB 1.1 OUT endpoint: it accepts bytes that `usb1_core` writes on its `epN_dout`/`epN_we` port and buffers them in a FIFO. It drives the core's `epN_full` back-pressure input and presents the buffered bytes to user logic as a first-word-fall-through valid/ready byte stream. It sits beside `usb1_core` in the board top level, complementing the IN-endpoint source logic.

## Interface
Parameters:
- `DEPTH_LOG2`, 7 — FIFO holds 2^DEPTH_LOG2 bytes; must be ≥ 6 (one 64-byte max packet).
- `OUT_EP_NUM`, 2 — endpoint number compared against `ep_sel` to recognise this endpoint's transactions.

Ports:
- `clk_i`  in  1  — single clock, same as `usb1_core`.
- `rst_i`  in  1  — asynchronous, active-low reset.
- `usb_rst`  in  1  — bus reset from core; synchronous flush.
- `usb_busy`  in  1  — core transaction-in-progress flag.
- `ep_sel`  in  4  — endpoint currently addressed by core.
- `crc16_err`  in  1  — core data-CRC error pulse.
- `ep_dout`  in  8  — received byte from core.
- `ep_we`  in  1  — byte write strobe from core.
- `ep_full`  out  1  — FIFO cannot accept a byte this cycle.
- `m_data`  out  8  — head byte.
- `m_valid`  out  1  — head byte valid (committed data present).
- `m_ready`  in  1  — user pops head when `m_valid & m_ready`.
- `level`  out  DEPTH_LOG2+1  — committed bytes available to the user.
- `pkt_cnt`  out  16  — committed packets since reset or flush; wraps at 0xFFFF→0.
- `overflow`  out  1  — sticky flag: a write arrived while the FIFO was full.

## Operation
- Pointers are `wr_ptr`, `commit_ptr` and `rd_ptr`, each DEPTH_LOG2+1 bits (the extra bit is the wrap bit).
- Fill: `wr_ptr − rd_ptr`; `ep_full = (fill == 2^DEPTH_LOG2)`.
- Committed level: `commit_ptr − rd_ptr`; `m_valid = (level != 0)`.
- Write: on `ep_we & ~ep_full`, store `ep_dout` at `mem[wr_ptr]` and increment `wr_ptr`.
- Write while full: the byte is dropped, `wr_ptr` holds, and `overflow` is set and held.
- Read: `m_data = mem[rd_ptr]`. On `m_valid & m_ready`, `rd_ptr` increments. `m_ready` while `!m_valid` is ignored.
- A push and a pop in the same cycle both take effect; `level` changes by the net amount.
- Packet FSM (`IDLE`, `RECV`):
  - `IDLE → RECV` on `ep_we` while `usb_busy & ep_sel==OUT_EP_NUM`. Entering `RECV` clears `err_seen`.
  - In `RECV`, `crc16_err` sets `err_seen`.
  - `RECV → IDLE` on the falling edge of `usb_busy`, detected against a registered copy of `usb_busy`.
  - On that exit, if `err_seen` is clear, the packet is good and `pkt_cnt` increments. Pointer handling on exit is defined under Configuration.
  - A zero-length packet never enters `RECV`, so `pkt_cnt` does not count it.
- `usb_rst` flush (synchronous, takes priority over everything): all pointers ← 0, state ← `IDLE`, `pkt_cnt` ← 0, `overflow` ← 0.

## Timing
- Reset values (async, `rst_i`=0): all pointers 0; state `IDLE`; `ep_full`=0, `m_valid`=0, `level`=0, `pkt_cnt`=0, `overflow`=0. `m_data` is don't-care.
- Write-to-visible latency:
  - Rollback off: 1 cycle after the `ep_we` edge.
  - Rollback on: 1 cycle after the cycle in which `usb_busy` is first sampled low.
- `ep_full` is combinational from registered pointers and updates on the cycle after the write that fills the FIFO. The core must see it before its next `ep_we`; the core writes at most once per 4 clocks at 48 MHz, so this holds.
- Pop: `rd_ptr` updates on the accepting edge, and the next byte appears on `m_data` in the same cycle as the update.
- Async reset in the middle of a packet discards all data and any partially received packet.

## Configuration
`USB_OUT_CRC_ROLLBACK_EN` selects pointer handling at packet end.

- **Defined:**
  - Written bytes stay invisible to the user until the packet ends.
  - Good packet: `commit_ptr ← wr_ptr`.
  - Bad packet (`err_seen` set): `wr_ptr ← commit_ptr`, discarding the packet's bytes, and `pkt_cnt` does not increment.
- **Undefined:**
  - `commit_ptr` tracks `wr_ptr` every cycle; bytes are visible 1 cycle after the write.
  - `crc16_err` affects only `pkt_cnt`; erroneous packet bytes remain in the FIFO.

## Structure
- Shared package (e.g. `usb_out_pkg`, or entries added to `usb1_defines.v`) holds:
  - FSM state encodings `ST_IDLE` / `ST_RECV`.
  - Default depth constant.
  - Max packet size 64.
- One sub-module: `usb_out_fifo_mem`, a simple dual-port RAM (synchronous write, asynchronous read, 2^DEPTH_LOG2×8). Pointers, flags, FSM and counters stay in `usb_ep_out_sink`.

## Test plan
- Reset, then a 4-byte packet (`ep_sel`=2, bytes 0x11, 0x22, 0x33, 0x44, `usb_busy` high and then low, `m_ready`=1) → bytes emerge in order, `pkt_cnt`=1, `level` returns to 0, `overflow`=0.
- With the macro defined, an 8-byte packet with one `crc16_err` pulse mid-packet → `m_valid` never rises, `level`=0, `pkt_cnt`=0. A following good 2-byte packet (0xA5, 0x5A) emerges intact.
- `DEPTH_LOG2`=6, `m_ready`=0, 65 writes → `ep_full`=1 after the 64th write, the 65th byte is dropped, `overflow`=1, and draining yields exactly 64 bytes.
- `ep_sel`=3 with `ep_we` pulses → FSM stays in `IDLE` and `pkt_cnt` unchanged.
- Continuous `m_ready`=1 with a write each cycle → push and pop coincide and `level` stays constant. Pointer wrap past 2^DEPTH_LOG2 preserves byte order across 300 bytes.
- `usb_rst` asserted mid-packet with 5 bytes queued → next cycle `level`=0, `m_valid`=0, `pkt_cnt`=0, `overflow`=0, state `IDLE`.
